// File: rtl/rob_multiway.sv
// Multi-lane reorder buffer: in-order allocate/commit, out-of-order writeback,
// and a selective tail walk on branch mispredict.
package rob_multiway_pkg;
  localparam int unsigned ROB_SIZE = 32;
  localparam int unsigned ROB_W    = $clog2(ROB_SIZE);
  localparam int unsigned PHYS_W   = 7;
  localparam int unsigned ARCH_W   = 5;
  localparam int unsigned PC_W     = 32;

  typedef enum logic [2:0] {
    UOP_ALU, UOP_BRANCH, UOP_JUMP, UOP_LOAD, UOP_STORE
  } uop_class_e;

  typedef struct packed {
    uop_class_e        uop_class;
    logic              uses_rd;
    logic [ARCH_W-1:0] rd_arch;
    logic [PC_W-1:0]   pc;
  } decoded_bundle_t;

  typedef struct packed {
    logic [ROB_W-1:0] rob_idx;
    logic [1:0]       epoch;
    logic             is_branch;
    logic             mispredict;
  } fu_wb_t;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              mispredict;
    logic [1:0]        epoch;
    logic              uses_rd;
    logic [ARCH_W-1:0] rd_arch;
    logic [PHYS_W-1:0] pd_new;
    logic [PHYS_W-1:0] pd_old;
    logic [PC_W-1:0]   pc;
    logic              is_branch;
    logic              is_load;
    logic              is_store;
  } rob_entry_t;
endpackage

module rob_multiway
  import rob_multiway_pkg::*;
#(
  parameter int unsigned ROB_SIZE_P = ROB_SIZE,
  parameter int unsigned ROB_W_P    = $clog2(ROB_SIZE_P),
  parameter int unsigned PHYS_W_P   = PHYS_W,
  parameter int unsigned ALLOC_W    = 2,
  parameter int unsigned COMMIT_W   = 2,
  parameter int unsigned WB_PORTS   = 3,
  parameter int unsigned SQUASH_W   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ALLOC_W-1:0]  alloc_valid_i,
  output logic                alloc_ready_o,
  input  decoded_bundle_t     alloc_bundle_i   [ALLOC_W],
  input  logic [PHYS_W_P-1:0] alloc_pd_new_i   [ALLOC_W],
  input  logic [PHYS_W_P-1:0] alloc_pd_old_i   [ALLOC_W],
  output logic [ROB_W_P-1:0]  alloc_rob_idx_o  [ALLOC_W],
  input  logic [WB_PORTS-1:0] wb_valid_i,
  input  fu_wb_t              wb_pkt_i         [WB_PORTS],
  output logic [COMMIT_W-1:0] commit_valid_o,
  input  logic                commit_ready_i,
  output rob_entry_t          commit_entry_o   [COMMIT_W],
  output logic [ROB_W_P-1:0]  commit_rob_idx_o [COMMIT_W],
  input  logic                flush_valid_i,
  output logic                recover_valid_o,
  output logic [ROB_W_P-1:0]  recover_rob_idx_o,
  output logic [SQUASH_W-1:0] squash_valid_o,
  output rob_entry_t          squash_entry_o   [SQUASH_W],
  output logic [ROB_W_P-1:0]  squash_rob_idx_o [SQUASH_W],
  output logic [1:0]          global_epoch_o,
  output logic [ROB_W_P:0]    count_o
);
  localparam int unsigned PTR_W = ROB_W_P + 1;

  typedef enum logic {ST_NORMAL, ST_RECOVERY} state_e;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [1:0]            epoch_q, epoch_d;
  logic [ROB_W_P-1:0]    rec_idx_q, rec_idx_d;
  logic [ROB_SIZE_P-1:0] unres_q, unres_d;
  rob_entry_t            mem_q [ROB_SIZE_P];
  rob_entry_t            mem_d [ROB_SIZE_P];

  logic [PTR_W-1:0]      count, alloc_n, commit_n, squash_n;
  logic                  alloc_fire;
  logic [WB_PORTS-1:0]   wb_hit;
  logic [ROB_W_P-1:0]    wb_idx [WB_PORTS];
  logic                  mp_fire, mp_take;
  logic [ROB_W_P-1:0]    mp_idx, mp_dist, rec_dist, cand_dist;
  logic                  c_prev, s_prev;

  // Read side: everything here depends only on registered state or same-cycle inputs.
  always_comb begin
    count         = tail_q - head_q;
    alloc_ready_o = (state_q == ST_NORMAL) &&
                    ((PTR_W'(ROB_SIZE_P) - count) >= PTR_W'(ALLOC_W));
    alloc_fire    = alloc_ready_o && (|alloc_valid_i);
    alloc_n       = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      alloc_rob_idx_o[i] = tail_q[ROB_W_P-1:0] + ROB_W_P'(i);
      if (alloc_fire && alloc_valid_i[i]) alloc_n = alloc_n + PTR_W'(1);
    end

    c_prev   = 1'b1;
    commit_n = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      commit_rob_idx_o[i] = head_q[ROB_W_P-1:0] + ROB_W_P'(i);
      commit_entry_o[i]   = mem_q[commit_rob_idx_o[i]];
      commit_valid_o[i]   = c_prev && (state_q == ST_NORMAL) && (PTR_W'(i) < count) &&
                            commit_entry_o[i].valid && commit_entry_o[i].done &&
                            (!commit_entry_o[i].is_store || (i == 0 && !(|unres_q)));
      c_prev = commit_valid_o[i];
      if (commit_ready_i && commit_valid_o[i]) commit_n = commit_n + PTR_W'(1);
    end

    s_prev   = 1'b1;
    squash_n = '0;
    for (int i = 0; i < SQUASH_W; i++) begin
      squash_rob_idx_o[i] = tail_q[ROB_W_P-1:0] - ROB_W_P'(i + 1);
      squash_entry_o[i]   = mem_q[squash_rob_idx_o[i]];
      squash_valid_o[i]   = s_prev && (state_q == ST_RECOVERY) &&
                            (squash_rob_idx_o[i] != rec_idx_q);
      s_prev = squash_valid_o[i];
      if (squash_valid_o[i]) squash_n = squash_n + PTR_W'(1);
    end

    // Oldest mispredicting branch among matching writebacks, measured from head.
    mp_fire   = 1'b0;
    mp_idx    = '0;
    mp_dist   = '1;
    cand_dist = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_idx[p] = ROB_W_P'(wb_pkt_i[p].rob_idx);
      wb_hit[p] = wb_valid_i[p] && mem_q[wb_idx[p]].valid &&
                  (mem_q[wb_idx[p]].epoch == wb_pkt_i[p].epoch);
      cand_dist = wb_idx[p] - head_q[ROB_W_P-1:0];
      if (wb_hit[p] && wb_pkt_i[p].is_branch && wb_pkt_i[p].mispredict &&
          (!mp_fire || cand_dist < mp_dist)) begin
        mp_fire = 1'b1;
        mp_idx  = wb_idx[p];
        mp_dist = cand_dist;
      end
    end
    rec_dist = rec_idx_q - head_q[ROB_W_P-1:0];
    mp_take  = mp_fire && ((state_q == ST_NORMAL) || (mp_dist < rec_dist));
  end

  // Next-state: writeback, then commit/squash invalidation, then allocation; flush last.
  always_comb begin
    mem_d     = mem_q;
    unres_d   = unres_q;
    state_d   = state_q;
    epoch_d   = epoch_q;
    rec_idx_d = rec_idx_q;
    head_d    = head_q + commit_n;
    tail_d    = tail_q + alloc_n - squash_n;

    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_hit[p]) begin
        mem_d[wb_idx[p]].done       = 1'b1;
        mem_d[wb_idx[p]].mispredict = wb_pkt_i[p].is_branch && wb_pkt_i[p].mispredict;
        if (wb_pkt_i[p].is_branch) unres_d[wb_idx[p]] = 1'b0;
      end
    end
    for (int i = 0; i < COMMIT_W; i++) begin
      if (commit_ready_i && commit_valid_o[i]) begin
        mem_d[commit_rob_idx_o[i]].valid = 1'b0;
        unres_d[commit_rob_idx_o[i]]     = 1'b0;
      end
    end
    for (int i = 0; i < SQUASH_W; i++) begin
      if (squash_valid_o[i]) begin
        mem_d[squash_rob_idx_o[i]].valid = 1'b0;
        unres_d[squash_rob_idx_o[i]]     = 1'b0;
      end
    end
    for (int i = 0; i < ALLOC_W; i++) begin
      if (alloc_fire && alloc_valid_i[i]) begin
        mem_d[alloc_rob_idx_o[i]]            = '0;
        mem_d[alloc_rob_idx_o[i]].valid      = 1'b1;
        mem_d[alloc_rob_idx_o[i]].epoch      = epoch_q;
        mem_d[alloc_rob_idx_o[i]].uses_rd    = alloc_bundle_i[i].uses_rd;
        mem_d[alloc_rob_idx_o[i]].rd_arch    = alloc_bundle_i[i].rd_arch;
        mem_d[alloc_rob_idx_o[i]].pd_new     = PHYS_W'(alloc_pd_new_i[i]);
        mem_d[alloc_rob_idx_o[i]].pd_old     = PHYS_W'(alloc_pd_old_i[i]);
        mem_d[alloc_rob_idx_o[i]].pc         = alloc_bundle_i[i].pc;
        mem_d[alloc_rob_idx_o[i]].is_branch  = (alloc_bundle_i[i].uop_class == UOP_BRANCH) ||
                                               (alloc_bundle_i[i].uop_class == UOP_JUMP);
        mem_d[alloc_rob_idx_o[i]].is_load    = (alloc_bundle_i[i].uop_class == UOP_LOAD);
        mem_d[alloc_rob_idx_o[i]].is_store   = (alloc_bundle_i[i].uop_class == UOP_STORE);
        unres_d[alloc_rob_idx_o[i]]          = mem_d[alloc_rob_idx_o[i]].is_branch;
      end
    end

    if (mp_take) begin
      state_d   = ST_RECOVERY;
      rec_idx_d = mp_idx;
      epoch_d   = epoch_q + 2'd1;
    end else if ((state_q == ST_RECOVERY) &&
                 (tail_d[ROB_W_P-1:0] == rec_idx_q + ROB_W_P'(1))) begin
      state_d = ST_NORMAL;
    end

    if (flush_valid_i) begin
      for (int k = 0; k < ROB_SIZE_P; k++) mem_d[k].valid = 1'b0;
      unres_d   = '0;
      head_d    = '0;
      tail_d    = '0;
      state_d   = ST_NORMAL;
      epoch_d   = '0;
      rec_idx_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_NORMAL;
      head_q    <= '0;
      tail_q    <= '0;
      epoch_q   <= '0;
      rec_idx_q <= '0;
      unres_q   <= '0;
      for (int k = 0; k < ROB_SIZE_P; k++) mem_q[k] <= '0;
    end else begin
      state_q   <= state_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      epoch_q   <= epoch_d;
      rec_idx_q <= rec_idx_d;
      unres_q   <= unres_d;
      mem_q     <= mem_d;
    end
  end

  assign recover_valid_o   = (state_q == ST_RECOVERY);
  assign recover_rob_idx_o = rec_idx_q;
  assign global_epoch_o    = epoch_q;
  assign count_o           = count;
endmodule

// File: tb/tb_rob_multiway.sv
// Directed bench for rob_multiway: fill/wrap, commit, store ordering, recovery walk,
// retarget, stale writebacks and flush during recovery.
module tb_rob_multiway;
  import rob_multiway_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      alloc_valid;
  logic            alloc_ready;
  decoded_bundle_t alloc_bundle [2];
  logic [6:0]      pd_new [2];
  logic [6:0]      pd_old [2];
  logic [4:0]      alloc_rob_idx [2];
  logic [2:0]      wb_valid;
  fu_wb_t          wb_pkt [3];
  logic [1:0]      commit_valid;
  logic            commit_ready;
  rob_entry_t      commit_entry [2];
  logic [4:0]      commit_rob_idx [2];
  logic            flush;
  logic            recover_valid;
  logic [4:0]      recover_rob_idx;
  logic [1:0]      squash_valid;
  rob_entry_t      squash_entry [2];
  logic [4:0]      squash_rob_idx [2];
  logic [1:0]      global_epoch;
  logic [5:0]      count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rob_multiway dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready),
    .alloc_bundle_i(alloc_bundle), .alloc_pd_new_i(pd_new), .alloc_pd_old_i(pd_old),
    .alloc_rob_idx_o(alloc_rob_idx),
    .wb_valid_i(wb_valid), .wb_pkt_i(wb_pkt),
    .commit_valid_o(commit_valid), .commit_ready_i(commit_ready),
    .commit_entry_o(commit_entry), .commit_rob_idx_o(commit_rob_idx),
    .flush_valid_i(flush),
    .recover_valid_o(recover_valid), .recover_rob_idx_o(recover_rob_idx),
    .squash_valid_o(squash_valid), .squash_entry_o(squash_entry),
    .squash_rob_idx_o(squash_rob_idx),
    .global_epoch_o(global_epoch), .count_o(count)
  );

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    alloc_valid = 2'b00;
    wb_valid    = 3'b000;
    flush       = 1'b0;
  endtask

  task automatic set_alloc(input uop_class_e c0, input uop_class_e c1);
    alloc_valid     = 2'b11;
    alloc_bundle[0] = '{uop_class: c0, uses_rd: 1'b1, rd_arch: 5'd3, pc: 32'h1000};
    alloc_bundle[1] = '{uop_class: c1, uses_rd: 1'b1, rd_arch: 5'd4, pc: 32'h1004};
    pd_new[0] = 7'd10; pd_new[1] = 7'd11;
    pd_old[0] = 7'd20; pd_old[1] = 7'd21;
  endtask

  task automatic set_wb(input int p, input int idx, input logic [1:0] ep,
                        input logic br, input logic mp);
    wb_valid[p] = 1'b1;
    wb_pkt[p]   = '{rob_idx: 5'(idx), epoch: ep, is_branch: br, mispredict: mp};
  endtask

  // Ten entries: idx1 and idx3 are branches, the rest ALU.
  task automatic alloc_ten();
    set_alloc(UOP_ALU, UOP_BRANCH); step();
    set_alloc(UOP_ALU, UOP_BRANCH); step();
    for (int g = 0; g < 3; g++) begin
      set_alloc(UOP_ALU, UOP_ALU); step();
    end
    idle();
  endtask

  task automatic do_flush();
    flush = 1'b1; step(); idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); commit_ready = 1'b0;
    wb_pkt[0] = '0; wb_pkt[1] = '0; wb_pkt[2] = '0;
    set_alloc(UOP_ALU, UOP_ALU); alloc_valid = 2'b00;
    step(); step();
    n_vec++; if (alloc_ready !== 1'b1) begin n_err++; $display("FAIL reset_alloc_ready: got %b want 1", alloc_ready); end
    n_vec++; if (alloc_rob_idx[0] !== 5'd0 || alloc_rob_idx[1] !== 5'd1) begin n_err++; $display("FAIL reset_alloc_idx: got %0d,%0d want 0,1", alloc_rob_idx[0], alloc_rob_idx[1]); end
    n_vec++; if (commit_valid !== 2'b00 || squash_valid !== 2'b00) begin n_err++; $display("FAIL reset_valids: got commit %b squash %b want 00 00", commit_valid, squash_valid); end
    n_vec++; if (commit_entry[0] !== '0) begin n_err++; $display("FAIL reset_commit_entry: got %h want 0", commit_entry[0]); end
    n_vec++; if (recover_valid !== 1'b0 || recover_rob_idx !== 5'd0 || global_epoch !== 2'd0 || count !== 6'd0) begin n_err++; $display("FAIL reset_state: got rv %b ridx %0d ep %0d cnt %0d want 0 0 0 0", recover_valid, recover_rob_idx, global_epoch, count); end
    #3 rst_n = 1'b1;
  endtask

  task automatic test_fill_wrap();
    for (int g = 0; g < 16; g++) begin
      set_alloc(UOP_ALU, UOP_ALU);
      if (g == 15) begin
        n_vec++; if (alloc_rob_idx[0] !== 5'd30 || alloc_rob_idx[1] !== 5'd31) begin n_err++; $display("FAIL fill_last_idx: got %0d,%0d want 30,31", alloc_rob_idx[0], alloc_rob_idx[1]); end
      end
      step();
    end
    idle();
    n_vec++; if (count !== 6'd32) begin n_err++; $display("FAIL fill_count: got %0d want 32", count); end
    n_vec++; if (alloc_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready: got %b want 0", alloc_ready); end
  endtask

  task automatic test_wb_commit();
    set_wb(0, 1, 2'd0, 1'b0, 1'b0); step(); idle();
    n_vec++; if (commit_valid !== 2'b00) begin n_err++; $display("FAIL wb1_commit_valid: got %b want 00", commit_valid); end
    set_wb(0, 0, 2'd0, 1'b0, 1'b0); step(); idle();
    n_vec++; if (commit_valid !== 2'b11) begin n_err++; $display("FAIL wb0_commit_valid: got %b want 11", commit_valid); end
    n_vec++; if (commit_rob_idx[1] !== 5'd1 || commit_entry[1].done !== 1'b1) begin n_err++; $display("FAIL wb0_lane1: got idx %0d done %b want 1 1", commit_rob_idx[1], commit_entry[1].done); end
    commit_ready = 1'b1; step(); commit_ready = 1'b0;
    n_vec++; if (count !== 6'd30 || alloc_ready !== 1'b1) begin n_err++; $display("FAIL commit2_count: got cnt %0d rdy %b want 30 1", count, alloc_ready); end
    n_vec++; if (alloc_rob_idx[0] !== 5'd0 || alloc_rob_idx[1] !== 5'd1) begin n_err++; $display("FAIL wrap_alloc_idx: got %0d,%0d want 0,1", alloc_rob_idx[0], alloc_rob_idx[1]); end
    do_flush();
    n_vec++; if (count !== 6'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count); end
  endtask

  task automatic test_store_rule();
    set_alloc(UOP_STORE, UOP_ALU); step();
    set_alloc(UOP_ALU, UOP_STORE); step();
    set_alloc(UOP_ALU, UOP_BRANCH); step(); idle();
    set_wb(0, 0, 2'd0, 1'b0, 1'b0); set_wb(1, 1, 2'd0, 1'b0, 1'b0); set_wb(2, 2, 2'd0, 1'b0, 1'b0); step(); idle();
    set_wb(0, 3, 2'd0, 1'b0, 1'b0); set_wb(1, 4, 2'd0, 1'b0, 1'b0); step(); idle();
    n_vec++; if (commit_valid !== 2'b00) begin n_err++; $display("FAIL store_blocked: got %b want 00", commit_valid); end
    set_wb(2, 5, 2'd0, 1'b1, 1'b0); step(); idle();
    n_vec++; if (commit_valid !== 2'b11) begin n_err++; $display("FAIL store_released: got %b want 11", commit_valid); end
    commit_ready = 1'b1; step();
    n_vec++; if (commit_valid !== 2'b01) begin n_err++; $display("FAIL store_lane1_wait: got %b want 01", commit_valid); end
    step();
    n_vec++; if (commit_valid !== 2'b11 || commit_rob_idx[0] !== 5'd3) begin n_err++; $display("FAIL store_lane0: got %b head %0d want 11 3", commit_valid, commit_rob_idx[0]); end
    step();
    n_vec++; if (commit_valid !== 2'b01 || count !== 6'd1) begin n_err++; $display("FAIL store_tail_one: got %b cnt %0d want 01 1", commit_valid, count); end
    step(); commit_ready = 1'b0;
    n_vec++; if (count !== 6'd0) begin n_err++; $display("FAIL store_drain: got %0d want 0", count); end
    do_flush();
  endtask

  task automatic test_recovery();
    alloc_ten();
    set_wb(0, 0, 2'd0, 1'b0, 1'b0); step(); idle();
    n_vec++; if (commit_valid !== 2'b01) begin n_err++; $display("FAIL rec_pre_commit: got %b want 01", commit_valid); end
    set_wb(1, 3, 2'd0, 1'b1, 1'b1); step(); idle();
    n_vec++; if (recover_valid !== 1'b1 || global_epoch !== 2'd1 || recover_rob_idx !== 5'd3) begin n_err++; $display("FAIL rec_enter: got rv %b ep %0d ridx %0d want 1 1 3", recover_valid, global_epoch, recover_rob_idx); end
    n_vec++; if (squash_valid !== 2'b11 || squash_rob_idx[0] !== 5'd9 || squash_rob_idx[1] !== 5'd8) begin n_err++; $display("FAIL rec_sq1: got %b %0d,%0d want 11 9,8", squash_valid, squash_rob_idx[0], squash_rob_idx[1]); end
    n_vec++; if (commit_valid !== 2'b00 || alloc_ready !== 1'b0) begin n_err++; $display("FAIL rec_block: got cv %b rdy %b want 00 0", commit_valid, alloc_ready); end
    step();
    n_vec++; if (squash_rob_idx[0] !== 5'd7 || count !== 6'd8 || recover_valid !== 1'b1) begin n_err++; $display("FAIL rec_sq2: got idx %0d cnt %0d rv %b want 7 8 1", squash_rob_idx[0], count, recover_valid); end
    step();
    n_vec++; if (squash_valid !== 2'b11 || squash_rob_idx[1] !== 5'd4 || count !== 6'd6) begin n_err++; $display("FAIL rec_sq3: got %b idx %0d cnt %0d want 11 4 6", squash_valid, squash_rob_idx[1], count); end
    step();
    n_vec++; if (recover_valid !== 1'b0 || count !== 6'd4 || squash_valid !== 2'b00) begin n_err++; $display("FAIL rec_exit: got rv %b cnt %0d sq %b want 0 4 00", recover_valid, count, squash_valid); end
    n_vec++; if (alloc_ready !== 1'b1 || alloc_rob_idx[0] !== 5'd4 || commit_valid !== 2'b01) begin n_err++; $display("FAIL rec_normal: got rdy %b idx %0d cv %b want 1 4 01", alloc_ready, alloc_rob_idx[0], commit_valid); end
    do_flush();
  endtask

  task automatic test_retarget();
    alloc_ten();
    set_wb(0, 0, 2'd0, 1'b0, 1'b0); step(); idle();
    set_wb(0, 3, 2'd0, 1'b1, 1'b1); step(); idle();
    set_wb(2, 1, 2'd0, 1'b1, 1'b1); step(); idle();
    n_vec++; if (recover_rob_idx !== 5'd1 || global_epoch !== 2'd2) begin n_err++; $display("FAIL rt_target: got ridx %0d ep %0d want 1 2", recover_rob_idx, global_epoch); end
    n_vec++; if (squash_rob_idx[0] !== 5'd7 || count !== 6'd8) begin n_err++; $display("FAIL rt_walk: got idx %0d cnt %0d want 7 8", squash_rob_idx[0], count); end
    // Younger mispredict plus a stale writeback to an already squashed slot.
    set_wb(0, 5, 2'd0, 1'b1, 1'b1); set_wb(1, 9, 2'd0, 1'b0, 1'b0); step(); idle();
    n_vec++; if (recover_rob_idx !== 5'd1 || global_epoch !== 2'd2 || count !== 6'd6) begin n_err++; $display("FAIL rt_younger: got ridx %0d ep %0d cnt %0d want 1 2 6", recover_rob_idx, global_epoch, count); end
    step();
    n_vec++; if (squash_valid !== 2'b11 || squash_rob_idx[0] !== 5'd3 || squash_rob_idx[1] !== 5'd2) begin n_err++; $display("FAIL rt_last_sq: got %b %0d,%0d want 11 3,2", squash_valid, squash_rob_idx[0], squash_rob_idx[1]); end
    step();
    n_vec++; if (recover_valid !== 1'b0 || count !== 6'd2 || commit_valid !== 2'b11) begin n_err++; $display("FAIL rt_exit: got rv %b cnt %0d cv %b want 0 2 11", recover_valid, count, commit_valid); end
    set_alloc(UOP_ALU, UOP_ALU); commit_ready = 1'b1; step(); idle(); commit_ready = 1'b0;
    n_vec++; if (count !== 6'd2 || alloc_rob_idx[0] !== 5'd4 || commit_rob_idx[0] !== 5'd2) begin n_err++; $display("FAIL b2b_alloc_commit: got cnt %0d tail %0d head %0d want 2 4 2", count, alloc_rob_idx[0], commit_rob_idx[0]); end
    set_wb(1, 2, 2'd0, 1'b0, 1'b0); step(); idle();
    n_vec++; if (commit_valid !== 2'b00) begin n_err++; $display("FAIL stale_epoch: got %b want 00", commit_valid); end
    set_wb(1, 2, 2'd2, 1'b0, 1'b0); step(); idle();
    n_vec++; if (commit_valid !== 2'b01) begin n_err++; $display("FAIL current_epoch: got %b want 01", commit_valid); end
  endtask

  task automatic test_flush_recovery();
    set_alloc(UOP_BRANCH, UOP_ALU); step(); idle();
    set_wb(0, 4, 2'd2, 1'b1, 1'b1); step(); idle();
    n_vec++; if (recover_valid !== 1'b1 || global_epoch !== 2'd3 || recover_rob_idx !== 5'd4) begin n_err++; $display("FAIL fr_enter: got rv %b ep %0d ridx %0d want 1 3 4", recover_valid, global_epoch, recover_rob_idx); end
    n_vec++; if (squash_valid !== 2'b01 || squash_rob_idx[0] !== 5'd5) begin n_err++; $display("FAIL fr_squash: got %b idx %0d want 01 5", squash_valid, squash_rob_idx[0]); end
    do_flush();
    n_vec++; if (count !== 6'd0 || recover_valid !== 1'b0 || global_epoch !== 2'd0) begin n_err++; $display("FAIL fr_clear: got cnt %0d rv %b ep %0d want 0 0 0", count, recover_valid, global_epoch); end
    n_vec++; if (alloc_ready !== 1'b1 || alloc_rob_idx[0] !== 5'd0 || alloc_rob_idx[1] !== 5'd1 || squash_valid !== 2'b00) begin n_err++; $display("FAIL fr_ready: got rdy %b idx %0d,%0d sq %b want 1 0,1 00", alloc_ready, alloc_rob_idx[0], alloc_rob_idx[1], squash_valid); end
  endtask

  initial begin
    test_reset();
    test_fill_wrap();
    test_wb_commit();
    test_store_rule();
    test_recovery();
    test_retarget();
    test_flush_recovery();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within 100000 time units");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/rob_multiway.md
# rob_multiway

Parametrised multi-lane reorder buffer sitting between rename/dispatch and the commit/free-list stage. Allocates up to ALLOC_W uops per cycle in program order and accepts WB_PORTS writebacks per cycle. Retires up to COMMIT_W completed uops per cycle. On a branch mispredict it performs selective recovery, walking the tail back by up to SQUASH_W entries per cycle and emitting each squashed entry so rename can restore its RAT and free list.

## Interface
- ROB_SIZE_P, default ROB_SIZE: entry count; power of two, ≥ 8.
- ROB_W_P, default $clog2(ROB_SIZE_P): index width.
- PHYS_W_P, default PHYS_W: physical register index width.
- ALLOC_W, default 2: allocation lanes.
- COMMIT_W, default 2: commit lanes.
- WB_PORTS, default 3: writeback ports.
- SQUASH_W, default 2: entries squashed per recovery cycle.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- alloc_valid  in  ALLOC_W  lane mask; must be a contiguous prefix from lane 0
- alloc_ready  out  1  all-or-none accept for the whole group
- alloc_bundle  in  ALLOC_W × decoded_bundle_t  decoded uops
- alloc_pd_new / alloc_pd_old  in  ALLOC_W × PHYS_W_P  new and previous phys dest
- alloc_rob_idx  out  ALLOC_W × ROB_W_P  tail+i (mod ROB_SIZE_P)
- wb_valid  in  WB_PORTS  writeback strobes (always accepted)
- wb_pkt  in  WB_PORTS × fu_wb_t  rob_idx, epoch, is_branch, mispredict
- commit_valid  out  COMMIT_W  contiguous prefix of retirable entries
- commit_ready  in  1  consumer takes all asserted lanes
- commit_entry  out  COMMIT_W × rob_entry_t;  commit_rob_idx  out  COMMIT_W × ROB_W_P
- flush_valid  in  1  synchronous full clear
- recover_valid  out  1  recovery in progress
- recover_rob_idx  out  ROB_W_P  index of the mispredicted branch
- squash_valid  out  SQUASH_W  lane i squashes entry tail-1-i
- squash_entry  out  SQUASH_W × rob_entry_t;  squash_rob_idx  out  SQUASH_W × ROB_W_P
- global_epoch  out  2  current speculation epoch
- count  out  ROB_W_P+1  occupied entries

## Operation
- Pointers head and tail are ROB_W_P+1 bits and wrap naturally. count = tail − head. Full when count == ROB_SIZE_P.
- alloc_ready = NORMAL state && (ROB_SIZE_P − count) ≥ ALLOC_W.
- On accept, each valid lane i writes entry tail+i with: valid=1, done=0, mispredict=0, epoch=global_epoch, uses_rd, rd_arch, pd_new, pd_old, pc, and is_branch/is_load/is_store from uop_class (BRANCH/JUMP count as branch). tail advances by popcount(alloc_valid).
- Writeback: a port matches when the target entry is valid and its epoch equals the packet epoch. A match sets done, and sets mispredict = is_branch && mispredict. A resolved branch clears its unresolved bit. Non-matching packets are ignored. If two ports hit the same index, the higher port number wins.
- Mispredict event: a matching packet with is_branch && mispredict. If several fire in one cycle, the oldest (smallest distance from head) is selected. At the next edge: state = RECOVERY, recover_rob_idx = selected index, global_epoch += 1 (wraps 3→0).
  - In RECOVERY, a new event on a branch older than recover_rob_idx retargets recover_rob_idx and increments the epoch again.
  - In RECOVERY, an event on a branch younger than recover_rob_idx is ignored.
- Commit (NORMAL only): lane i is valid iff lanes 0..i-1 are valid, i < count, entry head+i is valid and done, and the store rule holds.
- Store rule: a store may commit only in lane 0, and only if no unresolved branch exists anywhere in the ROB.
- On commit_ready, all asserted lanes retire: entries are invalidated and head advances by the lane count.
- RECOVERY walk: each cycle, squash_valid[i] = (tail−1−i) ≠ recover_rob_idx and all lanes j<i are valid. Squashed entries are invalidated and tail retreats by their count.
  - State returns to NORMAL at the edge where tail becomes recover_rob_idx+1.
  - recover_valid is high for every RECOVERY cycle. alloc_ready = 0 and commit_valid = 0 while recovering.
  - Writebacks remain active during RECOVERY.
- flush_valid has priority over all other activity. It sets head = tail = 0, invalidates every entry, clears all unresolved bits, sets state NORMAL, and sets global_epoch = 0.

## Timing
- Reset values: alloc_ready = 1, alloc_rob_idx[i] = i, commit_valid = 0, commit_entry = 0, squash_valid = 0, recover_valid = 0, recover_rob_idx = 0, global_epoch = 0, count = 0.
- alloc_ready, commit_valid, and squash_* are combinational from registered state.
- A writeback at edge N makes the entry commit-eligible in cycle N+1.
- recover_valid rises one cycle after the mispredict writeback.
- An allocation accepted in the same cycle as the mispredict carries the old epoch and is squashed by the walk.
- Walk latency = ceil((tail − recover_rob_idx − 1) / SQUASH_W) cycles. A mispredict on the youngest entry spends exactly one RECOVERY cycle, with squash_valid = 0.
- Simultaneous alloc and commit: count += alloc_n − commit_n.

## Test plan
- Reset, then allocate 16 groups of 2 -> count = 32, alloc_ready = 0. alloc_rob_idx wraps 30,31 → 0,1 after 2 commits.
- Writebacks to idx 1 then 0 in consecutive cycles -> commit_valid = 2'b11 the cycle after idx 0 is done. Both commit in one cycle and head advances by 2.
- Store at head with an unresolved branch at idx 5 -> commit_valid = 0 until idx 5 writes back. A store in lane 1 waits until it reaches lane 0.
- 10 entries (idx 0–9), mispredict at idx 3 -> recover_valid next cycle, epoch 0→1. Squash idx 9,8 / 7,6 / 5,4 over 3 cycles, then NORMAL with tail = 4.
- During that recovery, mispredict at idx 1 -> recover_rob_idx = 1, epoch = 2, walk continues down to tail = 2. A stale writeback carrying epoch 0 to a squashed index is ignored.
- flush_valid mid-recovery -> next cycle count = 0, recover_valid = 0, epoch = 0, alloc_rob_idx = 0,1.
